stopwatch_control: RTL and testbench



---
 rtl/stopwatch_control_if.sv | 23 ++
 rtl/stopwatch_control.sv | 150 +++++++++++++++
 tb/tb_stopwatch_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_control_if.sv
// Button/counter-chain bundle for stopwatch_control: raw button levels and
// max_reached in, tick/clear/display/status out. "master" is the button and counter side.
interface stopwatch_control_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       max_reached;
  logic       tick_en;
  logic       count_clr;
  logic       disp_freeze;
  logic       running;
  logic [2:0] state;

  modport master (
    output btn_start_stop, btn_clear, btn_lap, max_reached,
    input  tick_en, count_clr, disp_freeze, running, state
  );

  modport slave (
    input  btn_start_stop, btn_clear, btn_lap, max_reached,
    output tick_en, count_clr, disp_freeze, running, state
  );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch run/pause/lap/clear sequencer with a tenth-second prescaler.
// Define STOPWATCH_LAP_EN to build the LAP state and the btn_lap path.
module stopwatch_control #(
  parameter int TICK_DIV = 500000
) (
  input  logic               clk5,
  input  logic               reset,
  stopwatch_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    ss_sync_q, ss_sync_d, cl_sync_q, cl_sync_d;
  logic          ss_prev_q, ss_prev_d, cl_prev_q, cl_prev_d;
  logic          tick_q, tick_d, clr_q, clr_d;
  logic          run_q, run_d, freeze_q, freeze_d;
  logic          ev_ss, ev_cl, ev_lap;
  logic          in_run, at_tc, overflow, clr_act;

  assign ss_sync_d = {ss_sync_q[0], bus.btn_start_stop};
  assign cl_sync_d = {cl_sync_q[0], bus.btn_clear};
  assign ss_prev_d = ss_sync_q[1];
  assign cl_prev_d = cl_sync_q[1];
  assign ev_ss     = ss_sync_q[1] & ~ss_prev_q;
  assign ev_cl     = cl_sync_q[1] & ~cl_prev_q;

`ifdef STOPWATCH_LAP_EN
  logic [1:0] lp_sync_q, lp_sync_d;
  logic       lp_prev_q, lp_prev_d;

  assign lp_sync_d = {lp_sync_q[0], bus.btn_lap};
  assign lp_prev_d = lp_sync_q[1];
  assign ev_lap    = lp_sync_q[1] & ~lp_prev_q;

  always_ff @(posedge clk5) begin
    if (reset) begin
      lp_sync_q <= '0;
      lp_prev_q <= 1'b0;
    end else begin
      lp_sync_q <= lp_sync_d;
      lp_prev_q <= lp_prev_d;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = bus.btn_lap;
  assign ev_lap     = 1'b0;
`endif

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ss_sync_q <= '0;
      cl_sync_q <= '0;
      ss_prev_q <= 1'b0;
      cl_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      run_q     <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ss_sync_q <= ss_sync_d;
      cl_sync_q <= cl_sync_d;
      ss_prev_q <= ss_prev_d;
      cl_prev_q <= cl_prev_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      run_q     <= run_d;
      freeze_q  <= freeze_d;
    end
  end

  assign in_run   = (state_q == S_RUN) || (state_q == S_LAP);
  assign at_tc    = in_run && (presc_q == PRE_TC);
  assign overflow = at_tc && bus.max_reached;

  // Each state takes the highest-priority event it accepts; overflow overrides.
  always_comb begin
    state_d = state_q;
    clr_act = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_cl)      clr_act = 1'b1;
        else if (ev_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_ss)       state_d = S_PAUSE;
        else if (ev_lap) state_d = S_LAP;
      end
      S_LAP: begin
        if (ev_ss)       state_d = S_PAUSE;
        else if (ev_lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ev_cl) begin
          state_d = S_IDLE;
          clr_act = 1'b1;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (ev_cl) begin
          state_d = S_IDLE;
          clr_act = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (overflow) state_d = S_HALT;

    // Prescaler holds in PAUSE/HALT so a resume keeps the partial tenth.
    presc_d = presc_q;
    if (in_run)                presc_d = at_tc ? '0 : presc_q + 1'b1;
    else if (state_q == S_IDLE) presc_d = '0;
    if (clr_act)               presc_d = '0;
  end

  always_comb begin
    tick_d = at_tc && !bus.max_reached;
    clr_d  = clr_act;
    run_d  = (state_d == S_RUN) || (state_d == S_LAP);
`ifdef STOPWATCH_LAP_EN
    freeze_d = (state_d == S_LAP);
`else
    freeze_d = 1'b0;
`endif
  end

  assign bus.state       = state_q;
  assign bus.tick_en     = tick_q;
  assign bus.count_clr   = clr_q;
  assign bus.running     = run_q;
  assign bus.disp_freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control (TICK_DIV=4): directed vector table, lap/reset
// sequences and randomized button activity against an event-level reference model.
module tb_stopwatch_control;
  localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct {
    bit       ss, cl, mx;
    bit       e_tick, e_clr, e_run;
    bit [2:0] e_state;
  } vec_t;

  logic clk5 = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];

  always #5 clk5 = ~clk5;

  stopwatch_control_if bus();
  stopwatch_control #(.TICK_DIV(TD)) dut (.clk5(clk5), .reset(reset), .bus(bus));

  // Reference model: state codes are the published encodings; trans[state][event]
  // gives the next state (-1 = not accepted). Events: 0=clear, 1=start_stop, 2=lap.
  int trans[5][3] = '{'{0, 1, -1}, '{-1, 2, 3}, '{0, 1, -1}, '{-1, 2, 1}, '{0, -1, -1}};
  int m_state, m_phase;
  bit m_tick, m_clr, m_run, m_freeze;
  bit h_ss[3], h_cl[3], h_lp[3];

  task automatic check(string name, logic [2:0] act, logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(bit rst, bit ss, bit cl, bit lp, bit mx);
    bit ev[3];
    bit running_now, tc, taken, cleared;
    int nxt;
    if (rst) begin
      m_state = 0; m_phase = 0;
      {m_tick, m_clr, m_run, m_freeze} = 4'b0;
      for (int i = 0; i < 3; i++) begin h_ss[i] = 0; h_cl[i] = 0; h_lp[i] = 0; end
      return;
    end
    // An event reaches the FSM two edges after its rising level is first sampled.
    ev[0] = h_cl[1] & ~h_cl[2];
    ev[1] = h_ss[1] & ~h_ss[2];
    ev[2] = LAP_EN & h_lp[1] & ~h_lp[2];
    running_now = (m_state == 1) || (m_state == 3);
    tc = running_now && (m_phase == TD - 1);
    m_tick = tc && !mx;
    m_clr = 0; cleared = 0; taken = 0; nxt = m_state;
    for (int e = 0; e < 3; e++) begin
      if (!taken && ev[e] && trans[m_state][e] >= 0) begin
        taken = 1;
        nxt = trans[m_state][e];
        if (e == 0) begin m_clr = 1; cleared = 1; end
      end
    end
    if (tc && mx) nxt = 4;
    if (running_now) m_phase = (m_phase + 1) % TD;
    else if (m_state == 0) m_phase = 0;
    if (cleared) m_phase = 0;
    m_state = nxt;
    m_run = (nxt == 1) || (nxt == 3);
    m_freeze = (nxt == 3);
    h_ss[2] = h_ss[1]; h_ss[1] = h_ss[0]; h_ss[0] = ss;
    h_cl[2] = h_cl[1]; h_cl[1] = h_cl[0]; h_cl[0] = cl;
    h_lp[2] = h_lp[1]; h_lp[1] = h_lp[0]; h_lp[0] = lp;
  endtask

  task automatic cycle(bit rst, bit ss, bit cl, bit lp, bit mx);
    @(negedge clk5);
    reset = rst;
    bus.btn_start_stop = ss;
    bus.btn_clear = cl;
    bus.btn_lap = lp;
    bus.max_reached = mx;
    @(posedge clk5);
    model_step(rst, ss, cl, lp, mx);
    #1;
    check("model_state", bus.state, 3'(m_state));
    check("model_tick_en", {2'b0, bus.tick_en}, {2'b0, m_tick});
    check("model_count_clr", {2'b0, bus.count_clr}, {2'b0, m_clr});
    check("model_running", {2'b0, bus.running}, {2'b0, m_run});
    check("model_disp_freeze", {2'b0, bus.disp_freeze}, {2'b0, m_freeze});
  endtask

  task automatic press(int which);
    cycle(0, which == 1, which == 0, which == 2, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic add(int n, bit ss, bit cl, bit mx, bit tk, bit cr, bit rn, bit [2:0] st);
    for (int i = 0; i < n; i++) tbl.push_back('{ss, cl, mx, tk, cr, rn, st});
  endtask

  initial begin
    int ticks;
    bit lss, lcl, llp;
    // Directed sequence: start, tick cadence, pause/resume, clear rules, overflow.
    add(2, 1, 0, 0, 0, 0, 0, 0);  add(4, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1, 1);  add(3, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1, 1);  add(1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);  add(5, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 0, 2);  add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 1, 1);  add(1, 0, 0, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 1, 1);  add(2, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 1);  add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 2);  add(1, 0, 1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 2);  add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);  add(1, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0, 1, 1);  add(1, 0, 0, 0, 1, 0, 1, 1);
    add(3, 0, 0, 0, 0, 0, 1, 1);  add(1, 0, 0, 1, 0, 0, 0, 4);
    add(1, 1, 0, 0, 0, 0, 0, 4);  add(2, 0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 1, 0, 0, 0, 0, 4);  add(1, 0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 1, 0, 0);  add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);  add(1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);  add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 1, 0, 0, 0, 0, 2);  add(1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 1, 0, 0);  add(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    check("reset_state", bus.state, 3'd0);
    check("reset_outputs", {bus.tick_en, bus.count_clr, bus.running}, 3'b000);
    check("reset_freeze", {2'b0, bus.disp_freeze}, 3'd0);

    foreach (tbl[i]) begin
      cycle(0, tbl[i].ss, tbl[i].cl, 0, tbl[i].mx);
      check("vec_state", bus.state, tbl[i].e_state);
      check("vec_tick_en", {2'b0, bus.tick_en}, {2'b0, tbl[i].e_tick});
      check("vec_count_clr", {2'b0, bus.count_clr}, {2'b0, tbl[i].e_clr});
      check("vec_running", {2'b0, bus.running}, {2'b0, tbl[i].e_run});
    end

    // Lap toggling while running, then reset from LAP (RUN without the lap path).
    press(1);
    check("lap_pre_state", bus.state, 3'd1);
    press(2);
    check("lap_state", bus.state, LAP_EN ? 3'd3 : 3'd1);
    check("lap_freeze", {2'b0, bus.disp_freeze}, {2'b0, LAP_EN});
    check("lap_running", {2'b0, bus.running}, 3'd1);
    ticks = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      cycle(0, 0, 0, 0, 0);
      ticks += int'(bus.tick_en);
    end
    check("lap_ticks", 3'(ticks), 3'd2);
    press(2);
    check("unlap_state", bus.state, 3'd1);
    check("unlap_freeze", {2'b0, bus.disp_freeze}, 3'd0);
    press(2);
    cycle(1, 0, 0, 0, 0);
    check("rst_mid_state", bus.state, 3'd0);
    check("rst_mid_outputs", {bus.tick_en, bus.count_clr, bus.running}, 3'b000);
    check("rst_mid_freeze", {2'b0, bus.disp_freeze}, 3'd0);

    // Randomized button levels, saturation flag and occasional reset.
    lss = 0; lcl = 0; llp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) lss = ~lss;
      if ($urandom_range(0, 11) == 0) lcl = ~lcl;
      if ($urandom_range(0, 7) == 0) llp = ~llp;
      cycle($urandom_range(0, 399) == 0, lss, lcl, llp, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
